// File: rtl/atomic_cmd_arbiter.sv
// Round-robin arbiter sharing the atomic ALU command port between requesters.
// The datapath is held from accept to response so a CAS cannot be interleaved.
module atomic_cmd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CMD_W   = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*CMD_W-1:0] req_cmd,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     rsp_cas_ok,
  output logic                     rsp_err,
  output logic [CMD_W-1:0]         dp_cmd,
  output logic                     dp_start,
  input  logic                     dp_done,
  input  logic [DATA_W-1:0]        dp_result,
  input  logic                     dp_z,
  output logic                     busy,
  output logic [2:0]               grant_id
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t state, nstate;

  logic [2:0]         rr_ptr;
  logic [15:0]        cnt;
  logic               win_found;
  int                 win_idx;
  logic               timed_out;
  logic               is_cas;
  logic [NUM_REQ-1:0] one;

  assign one       = NUM_REQ'(1);
  assign timed_out = (cnt == 16'(TIMEOUT - 1));
  assign is_cas    = (dp_cmd[CMD_W-1 -: 3] == 3'b111);

  // first valid requester at or after rr_ptr, wrapping
  always_comb begin
    win_found = 1'b0;
    win_idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req_valid[(int'(rr_ptr) + i) % NUM_REQ]) begin
        win_found = 1'b1;
        win_idx   = (int'(rr_ptr) + i) % NUM_REQ;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (win_found) nstate = ISSUE;
      ISSUE:   nstate = WAIT;
      WAIT:    if (dp_done || timed_out) nstate = RESP;
      RESP:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign dp_start  = (state == ISSUE);
  assign req_ready = (state == IDLE && win_found) ? (one << win_idx) : '0;
  assign rsp_valid = (state == RESP) ? (one << grant_id) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_cmd     <= '0;
      grant_id   <= '0;
      rr_ptr     <= '0;
      cnt        <= '0;
      rsp_data   <= '0;
      rsp_cas_ok <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (win_found) begin
            dp_cmd   <= req_cmd[win_idx*CMD_W +: CMD_W];
            grant_id <= 3'(win_idx);
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          if (dp_done) begin
            rsp_data   <= dp_result;
            rsp_cas_ok <= is_cas & dp_z;
            rsp_err    <= 1'b0;
          end else if (timed_out) begin
            rsp_data   <= '0;
            rsp_cas_ok <= 1'b0;
            rsp_err    <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RESP: begin
          rr_ptr <= (int'(grant_id) == NUM_REQ - 1) ? 3'd0
                                                    : grant_id + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_atomic_cmd_arbiter.sv
// Randomized bench for atomic_cmd_arbiter against a transaction-level
// round-robin model; bench also plays the requesters and the datapath.
module tb_atomic_cmd_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*12-1:0] req_cmd;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [31:0]     rsp_data;
  logic            rsp_cas_ok;
  logic            rsp_err;
  logic [11:0]     dp_cmd;
  logic            dp_start;
  logic            dp_done;
  logic [31:0]     dp_result;
  logic            dp_z;
  logic            busy;
  logic [2:0]      grant_id;

  logic [11:0] cmds [N];

  int          n_chk = 0;
  int          n_bad = 0;
  int          ptr;
  logic [31:0] exp_data;
  logic        exp_ok;
  logic        exp_err;

  always #5 clk = ~clk;

  always_comb begin
    req_cmd = '0;
    for (int i = 0; i < N; i++) req_cmd[i*12 +: 12] = cmds[i];
  end

  atomic_cmd_arbiter #(
    .NUM_REQ(N), .CMD_W(12), .DATA_W(32), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_cmd(req_cmd),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_cas_ok(rsp_cas_ok),
    .rsp_err(rsp_err), .dp_cmd(dp_cmd),
    .dp_start(dp_start), .dp_done(dp_done),
    .dp_result(dp_result), .dp_z(dp_z),
    .busy(busy), .grant_id(grant_id)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int i = 0; i < N; i++)
      if (m[(p + i) % N]) return (p + i) % N;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    ptr      = 0;
    exp_data = '0;
    exp_ok   = 1'b0;
    exp_err  = 1'b0;
  endtask

  task automatic rand_cmds();
    for (int i = 0; i < N; i++) begin
      cmds[i] = 12'($urandom);
      if ($urandom_range(1, 0) == 1) cmds[i][11:9] = 3'b111;
    end
  endtask

  // one full operation: d = WAIT cycles before dp_done (d >= TO -> timeout)
  task automatic txn(input logic [N-1:0] m, input logic [N-1:0] mb,
                     input int d, input logic [31:0] res,
                     input logic z, input logic early);
    int         w;
    logic       ok;
    logic [11:0] cw;
    w  = pick(m, ptr);
    cw = cmds[w];
    ok = (d < TO);
    req_valid = m;
    @(negedge clk);
    chk("hold_data", rsp_data, exp_data);
    chk("hold_cas", rsp_cas_ok, exp_ok);
    chk("hold_err", rsp_err, exp_err);
    chk("idle_rsp", rsp_valid, 0);
    chk("idle_busy", busy, 0);
    chk("ready", req_ready, 1 << w);
    tick();
    req_valid = mb;
    dp_done   = early;
    for (int i = 0; i < N; i++) cmds[i] = 12'($urandom);
    @(negedge clk);
    chk("start", dp_start, 1);
    chk("dp_cmd", dp_cmd, cw);
    chk("gid", grant_id, w);
    chk("ready_busy", req_ready, 0);
    for (int k = 1; k <= TO; k++) begin
      tick();
      dp_done   = (k == d + 1);
      dp_result = dp_done ? res : $urandom;
      dp_z      = dp_done ? z : 1'($urandom);
      @(negedge clk);
      chk("wait_busy", busy, 1);
      chk("wait_start", dp_start, 0);
      chk("wait_rsp", rsp_valid, 0);
      chk("wait_cmd", dp_cmd, cw);
      if (k == d + 1) break;
    end
    tick();
    dp_done  = 1'b0;
    exp_data = ok ? res : 32'h0;
    exp_ok   = ok && (cw[11:9] == 3'b111) && z;
    exp_err  = !ok;
    @(negedge clk);
    chk("rsp_valid", rsp_valid, 1 << w);
    chk("rsp_data", rsp_data, exp_data);
    chk("rsp_cas", rsp_cas_ok, exp_ok);
    chk("rsp_err", rsp_err, exp_err);
    ptr = (w + 1) % N;
    tick();
  endtask

  task automatic check_reset_outs(input string tag);
    chk(tag, {req_ready, rsp_valid, rsp_data, rsp_cas_ok, rsp_err,
              dp_cmd, dp_start, busy, grant_id}, 0);
  endtask

  task automatic do_reset();
    req_valid = '0;
    dp_done   = 1'b0;
    rst_n     = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    model_reset();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    dp_done   = 1'b0;
    dp_result = '0;
    dp_z      = 1'b0;
    for (int i = 0; i < N; i++) cmds[i] = '0;
    model_reset();
    repeat (2) tick();
    @(negedge clk);
    check_reset_outs("reset_outs");
    tick();
    rst_n = 1'b1;
    tick();

    // single request from requester 2
    cmds[2] = 12'h053;
    txn(4'b0100, 4'b0000, 2, 32'h0000_00AB, 1'b0, 1'b0);

    // all requesting from reset: grants 0,1,2,3,0
    do_reset();
    for (int i = 0; i < 5; i++) begin
      rand_cmds();
      txn(4'b1111, 4'b1111, 1, $urandom, 1'($urandom), 1'b0);
    end

    // CAS success, CAS fail, non-CAS with z=1
    for (int i = 0; i < N; i++) cmds[i] = 12'hE4A;
    txn(4'b1111, 4'b0000, 1, 32'h1234_5678, 1'b1, 1'b1);
    for (int i = 0; i < N; i++) cmds[i] = 12'hE4A;
    txn(4'b1111, 4'b0000, 0, 32'h0000_0001, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) cmds[i] = 12'h24A;
    txn(4'b1111, 4'b0000, 3, 32'hDEAD_BEEF, 1'b1, 1'b0);

    // timeout, then a late dp_done in IDLE
    rand_cmds();
    txn(4'b0001, 4'b0000, 20, 32'hFFFF_FFFF, 1'b1, 1'b0);
    dp_done = 1'b1;
    @(negedge clk);
    chk("late_done_rsp", rsp_valid, 0);
    chk("late_done_busy", busy, 0);
    tick();
    dp_done = 1'b0;
    @(negedge clk);
    chk("late_done_rsp2", rsp_valid, 0);
    chk("late_done_err", rsp_err, 1);
    tick();

    // reset two cycles after dp_start
    rand_cmds();
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    check_reset_outs("mid_wait_rst");
    dp_done = 1'b1;
    tick();
    dp_done = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    tick();
    dp_done = 1'b1;
    @(negedge clk);
    chk("stale_rsp", rsp_valid, 0);
    chk("stale_busy", busy, 0);
    tick();
    dp_done = 1'b0;
    rand_cmds();
    txn(4'b1111, 4'b0000, 1, $urandom, 1'b0, 1'b0);

    // requester 1 withdraws while 3 is in WAIT
    do_reset();
    rand_cmds();
    txn(4'b0010, 4'b0000, 0, $urandom, 1'b0, 1'b0);
    rand_cmds();
    txn(4'b1010, 4'b1000, 2, $urandom, 1'b0, 1'b0);
    rand_cmds();
    txn(4'b0100, 4'b0000, 1, $urandom, 1'b0, 1'b0);

    // random traffic
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(5, 0) == 0) begin
        req_valid = '0;
        dp_done   = 1'($urandom);
        @(negedge clk);
        chk("idle_ready", req_ready, 0);
        chk("idle_busy_r", busy, 0);
        chk("idle_rsp_r", rsp_valid, 0);
        tick();
        dp_done = 1'b0;
      end else begin
        logic [N-1:0] m;
        m = N'($urandom_range(15, 1));
        rand_cmds();
        txn(m, N'($urandom), $urandom_range(10, 0), $urandom,
            1'($urandom), 1'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
